// File: rtl/sha256_result_checker_if.sv
// Handshake and data bundle between the rolled SHA-256 transform, the
// result checker and the work-reporting logic that drains golden nonces.
interface sha256_result_checker_if;
   logic         rdy;
   logic [255:0] tx_hash;
   logic [255:0] mid_state;
   logic [31:0]  job_nonce;
   logic         out_valid;
   logic         out_ready;
   logic [31:0]  out_nonce;
   logic [31:0]  out_h7;
   logic [31:0]  hash_count;
   logic [15:0]  drop_count;

   // Checker side: consumes transform results, produces the nonce stream.
   modport slave (
      input  rdy, tx_hash, mid_state, job_nonce, out_ready,
      output out_valid, out_nonce, out_h7, hash_count, drop_count
   );

   // Environment side: drives transform results, drains the nonce stream.
   modport master (
      output rdy, tx_hash, mid_state, job_nonce, out_ready,
      input  out_valid, out_nonce, out_h7, hash_count, drop_count
   );
endinterface

// File: rtl/sha256_result_checker.sv
// SHA-256 result checker: captures the transform round state on rdy, adds
// the job midstate one 32-bit word per cycle (feed-forward), tests digest
// word 7 against a leading-zero difficulty and queues golden nonces.
module sha256_result_checker #(
   parameter int DIFF_BITS = 32,
   parameter int DEPTH     = 4
) (
   input logic                     clk,
   input logic                     reset,
   sha256_result_checker_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   // Bits of word 7 that must be zero; an empty mask makes every hash golden.
   localparam logic [31:0] GOLD_MASK =
      (DIFF_BITS == 0) ? 32'h0 : ~(32'hFFFF_FFFF >> DIFF_BITS);

   typedef enum logic [1:0] {IDLE, ADD, CHECK} state_t;

   state_t       state_reg, state_next;
   logic         armed_reg;
   logic [2:0]   idx_reg;
   logic [31:0]  tx_q_reg  [8];
   logic [31:0]  mid_q_reg [8];
   logic [31:0]  sum_reg   [8];
   logic [31:0]  nonce_q_reg;
   logic [31:0]  hash_count_reg;
   logic [15:0]  drop_count_reg;

   logic [31:0]  tx_word  [8];
   logic [31:0]  mid_word [8];
   logic [31:0]  add_word;

   logic         accept, overrun, in_check;
   logic         golden, empty, full, pop, push, fifo_drop;
   logic [1:0]   drop_inc;
   logic [16:0]  drop_sum;

   logic [PW-1:0] wr_ptr_reg, rd_ptr_reg, wr_ptr_next, rd_ptr_next;
   logic [31:0]   mem_nonce [DEPTH];
   logic [31:0]   mem_h7    [DEPTH];
   logic [31:0]   head_nonce_reg, head_nonce_next;
   logic [31:0]   head_h7_reg, head_h7_next;

   // Split the flat 256-bit buses into 32-bit words (word i = bits 32i+31:32i).
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_word
         assign tx_word[gi]  = bus.tx_hash[32*gi +: 32];
         assign mid_word[gi] = bus.mid_state[32*gi +: 32];
      end
   endgenerate

   // The single feed-forward adder, steered by the word index.
   assign add_word = tx_q_reg[idx_reg] + mid_q_reg[idx_reg];

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   // Next-state logic; a strobe while busy is an overrun and is discarded.
   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      overrun    = 1'b0;
      in_check   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.rdy && armed_reg) begin
               accept     = 1'b1;
               state_next = ADD;
            end
         end
         ADD: begin
            overrun = bus.rdy;
            if (idx_reg == 3'd7) state_next = CHECK;
         end
         CHECK: begin
            overrun    = bus.rdy;
            in_check   = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // The first strobe after reset carries no job; it only arms the checker.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                         armed_reg <= 1'b0;
      else if (bus.rdy && !armed_reg)    armed_reg <= 1'b1;
   end

   // Job capture and the word-serial feed-forward sum.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_reg     <= 3'd0;
         nonce_q_reg <= 32'h0;
         for (int i = 0; i < 8; i++) begin
            tx_q_reg[i]  <= 32'h0;
            mid_q_reg[i] <= 32'h0;
            sum_reg[i]   <= 32'h0;
         end
      end else if (accept) begin
         idx_reg     <= 3'd0;
         nonce_q_reg <= bus.job_nonce;
         for (int i = 0; i < 8; i++) begin
            tx_q_reg[i]  <= tx_word[i];
            mid_q_reg[i] <= mid_word[i];
         end
      end else if (state_reg == ADD) begin
         sum_reg[idx_reg] <= add_word;
         idx_reg          <= idx_reg + 3'd1;
      end
   end

   assign golden    = ((sum_reg[7] & GOLD_MASK) == 32'h0);
   assign empty     = (wr_ptr_reg == rd_ptr_reg);
   assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign pop       = !empty && bus.out_ready;
   // A simultaneous pop frees the slot, so a full FIFO can still take the push.
   assign push      = in_check && golden && (!full || pop);
   assign fifo_drop = in_check && golden && full && !pop;
   assign drop_inc  = {1'b0, overrun} + {1'b0, fifo_drop};
   assign drop_sum  = {1'b0, drop_count_reg} + {15'h0, drop_inc};

   // Hash counter wraps; drop counter saturates.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hash_count_reg <= 32'h0;
         drop_count_reg <= 16'h0;
      end else begin
         if (in_check) hash_count_reg <= hash_count_reg + 32'd1;
         drop_count_reg <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
   end

   // FIFO storage; stale contents are made unreachable by the pointer reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_nonce[wr_ptr_reg[AW-1:0]] <= nonce_q_reg;
         mem_h7[wr_ptr_reg[AW-1:0]]    <= sum_reg[7];
      end
   end

   // Work out the head after this edge; hold the old head once drained.
   always_comb begin
      rd_ptr_next     = rd_ptr_reg + {{AW{1'b0}}, pop};
      wr_ptr_next     = wr_ptr_reg + {{AW{1'b0}}, push};
      head_nonce_next = head_nonce_reg;
      head_h7_next    = head_h7_reg;
      if (rd_ptr_next != wr_ptr_next) begin
         if (push && (rd_ptr_next == wr_ptr_reg)) begin
            head_nonce_next = nonce_q_reg;
            head_h7_next    = sum_reg[7];
         end else begin
            head_nonce_next = mem_nonce[rd_ptr_next[AW-1:0]];
            head_h7_next    = mem_h7[rd_ptr_next[AW-1:0]];
         end
      end
   end

   // FIFO pointers and registered head entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         head_nonce_reg <= 32'h0;
         head_h7_reg    <= 32'h0;
      end else begin
         wr_ptr_reg     <= wr_ptr_next;
         rd_ptr_reg     <= rd_ptr_next;
         head_nonce_reg <= head_nonce_next;
         head_h7_reg    <= head_h7_next;
      end
   end

   assign bus.out_valid  = !empty;
   assign bus.out_nonce  = head_nonce_reg;
   assign bus.out_h7     = head_h7_reg;
   assign bus.hash_count = hash_count_reg;
   assign bus.drop_count = drop_count_reg;

endmodule

// File: tb/tb_sha256_result_checker.sv
// Randomised and directed bench for sha256_result_checker against a
// transaction-level model of accept/overrun/check timing and the nonce queue.
module tb_sha256_result_checker;

   localparam int DEPTH = 4;
   localparam int DIFF  = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   sha256_result_checker_if bus();
   sha256_result_checker_if bus31();

   sha256_result_checker #(.DIFF_BITS(DIFF), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );
   sha256_result_checker #(.DIFF_BITS(31), .DEPTH(DEPTH)) dut31 (
      .clk(clk), .reset(reset), .bus(bus31)
   );

   // The DIFF_BITS=31 instance sees exactly the same stimulus.
   assign bus31.rdy       = bus.rdy;
   assign bus31.tx_hash   = bus.tx_hash;
   assign bus31.mid_state = bus.mid_state;
   assign bus31.job_nonce = bus.job_nonce;
   assign bus31.out_ready = bus.out_ready;

   int checks   = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference model: job acceptance, busy window, queue of golden results.
   bit          m_armed;
   int          m_busy;        // edges still to go before IDLE again
   logic [31:0] m_pnonce, m_ph7;
   logic [63:0] mq[$];
   logic [31:0] m_hash;
   logic [15:0] m_drop;
   logic [31:0] m_hnonce, m_hh7;
   bit          seen_bad;

   task automatic model_reset();
      m_armed = 0; m_busy = 0; m_pnonce = 0; m_ph7 = 0;
      mq.delete(); m_hash = 0; m_drop = 0; m_hnonce = 0; m_hh7 = 0;
   endtask

   task automatic model_drop();
      if (m_drop != 16'hFFFF) m_drop++;
   endtask

   // Apply what happens at the coming clock edge, using the current inputs.
   task automatic model_edge();
      bit is_busy, is_check, pop, full_before;
      if (reset) begin
         model_reset();
         return;
      end
      is_busy     = (m_busy > 0);
      is_check    = (m_busy == 1);
      full_before = (mq.size() == DEPTH);
      pop         = (mq.size() > 0) && bus.out_ready;
      if (is_busy) m_busy--;
      if (pop) void'(mq.pop_front());
      if (is_check) begin
         m_hash++;
         if ((m_ph7 >> (32 - DIFF)) == 0) begin
            if (!full_before || pop) mq.push_back({m_pnonce, m_ph7});
            else model_drop();
         end
      end
      if (bus.rdy) begin
         if (!m_armed) m_armed = 1;
         else if (is_busy) model_drop();
         else begin
            m_pnonce = bus.job_nonce;
            m_ph7    = bus.tx_hash[255:224] + bus.mid_state[255:224];
            m_busy   = 9;
         end
      end
      if (mq.size() > 0) {m_hnonce, m_hh7} = mq[0];
   endtask

   task automatic compare_all();
      check_eq("out_valid",  bus.out_valid, (mq.size() > 0));
      check_eq("hash_count", bus.hash_count, m_hash);
      check_eq("drop_count", bus.drop_count, m_drop);
      check_eq("out_nonce",  bus.out_nonce, m_hnonce);
      check_eq("out_h7",     bus.out_h7, m_hh7);
      if (bus.out_valid && bus.out_nonce == 32'hDEADBEEF) seen_bad = 1;
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic fire(input logic [255:0] tx, input logic [255:0] mid, input logic [31:0] nonce);
      bus.tx_hash   = tx;
      bus.mid_state = mid;
      bus.job_nonce = nonce;
      bus.rdy       = 1'b1;
      $display("txn t=%0t nonce=%h h7=%h ready=%0d", $time, nonce,
               tx[255:224] + mid[255:224], bus.out_ready);
      step();
      bus.rdy = 1'b0;
   endtask

   // Asynchronous reset asserted between edges, held across one edge.
   task automatic do_reset();
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      compare_all();
      step();
      reset = 1'b0;
   endtask

   function automatic logic [255:0] rand256();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom();
      return v;
   endfunction

   localparam logic [255:0] TX_ONES = {8{32'hFFFF_FFFF}};
   localparam logic [255:0] MID_ONE = {8{32'h0000_0001}};
   localparam logic [255:0] MID_TWO = {8{32'h0000_0002}};

   initial begin
      logic [255:0] tx, mid;
      reset = 1'b1;
      bus.rdy = 1'b0; bus.tx_hash = '0; bus.mid_state = '0;
      bus.job_nonce = '0; bus.out_ready = 1'b0;
      seen_bad = 0;
      model_reset();
      idle(2);
      check_eq("rst_valid", bus.out_valid, 1'b0);
      check_eq("rst_hash", bus.hash_count, 32'h0);
      reset = 1'b0;

      // 1: first strobe only arms
      fire(rand256(), rand256(), $urandom());
      idle(12);
      check_eq("s1_hash", bus.hash_count, 32'h0);
      check_eq("s1_valid", bus.out_valid, 1'b0);
      check_eq("s1_drop", bus.drop_count, 16'h0);

      // 2: golden hit appears after the CHECK edge
      fire(TX_ONES, MID_ONE, 32'h1234_5678);
      idle(8);
      check_eq("s2_early_valid", bus.out_valid, 1'b0);
      idle(1);
      check_eq("s2_valid", bus.out_valid, 1'b1);
      check_eq("s2_nonce", bus.out_nonce, 32'h1234_5678);
      check_eq("s2_h7", bus.out_h7, 32'h0);
      check_eq("s2_hash", bus.hash_count, 32'd1);
      bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;
      check_eq("s2_drained", bus.out_valid, 1'b0);
      check_eq("s2_hold_nonce", bus.out_nonce, 32'h1234_5678);

      // 3: H7=1 misses at 32 bits, hits at 31 bits
      do_reset();
      fire(rand256(), rand256(), $urandom());
      fire(TX_ONES, MID_TWO, 32'hCAFE_0003);
      idle(9);
      check_eq("s3_d32_valid", bus.out_valid, 1'b0);
      check_eq("s3_d32_hash", bus.hash_count, 32'd1);
      check_eq("s3_d31_valid", bus31.out_valid, 1'b1);
      check_eq("s3_d31_h7", bus31.out_h7, 32'h1);
      check_eq("s3_d31_nonce", bus31.out_nonce, 32'hCAFE_0003);
      check_eq("s3_d31_hash", bus31.hash_count, 32'd1);
      bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;

      // 4: fifth hit against a full FIFO is dropped
      do_reset();
      fire(rand256(), rand256(), $urandom());
      for (int k = 1; k <= 5; k++) begin
         fire(TX_ONES, MID_ONE, k);
         idle(63);
      end
      check_eq("s4_drop", bus.drop_count, 16'd1);
      check_eq("s4_hash", bus.hash_count, 32'd5);
      bus.out_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         check_eq("s4_head", bus.out_nonce, k);
         step();
      end
      bus.out_ready = 1'b0;
      check_eq("s4_empty", bus.out_valid, 1'b0);
      check_eq("s4_hold", bus.out_nonce, 32'd4);

      // 6: push and pop in the same CHECK cycle on a full FIFO
      for (int k = 11; k <= 14; k++) begin
         fire(TX_ONES, MID_ONE, k);
         idle(63);
      end
      fire(TX_ONES, MID_ONE, 32'd15);
      idle(8);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      check_eq("s6_drop", bus.drop_count, 16'd1);
      check_eq("s6_head", bus.out_nonce, 32'd12);
      bus.out_ready = 1'b1;
      for (int k = 12; k <= 15; k++) begin
         check_eq("s6_order", bus.out_nonce, k);
         step();
      end
      bus.out_ready = 1'b0;
      check_eq("s6_empty", bus.out_valid, 1'b0);

      // 5: overrun at T+5 is dropped, strobe at T+10 accepted
      do_reset();
      fire(rand256(), rand256(), $urandom());
      bus.out_ready = 1'b1;
      seen_bad = 0;
      fire(TX_ONES, MID_ONE, 32'h0000_00A1);
      idle(4);
      fire(TX_ONES, MID_ONE, 32'hDEAD_BEEF);
      idle(4);
      check_eq("s5_drop", bus.drop_count, 16'd1);
      check_eq("s5_hash", bus.hash_count, 32'd1);
      fire(TX_ONES, MID_ONE, 32'h0000_00C3);
      idle(10);
      check_eq("s5_hash2", bus.hash_count, 32'd2);
      check_eq("s5_drop2", bus.drop_count, 16'd1);
      check_eq("s5_no_deadbeef", seen_bad, 1'b0);

      // mid-operation reset discards the job and requires re-arming
      fire(TX_ONES, MID_ONE, 32'd77);
      idle(4);
      do_reset();
      fire(TX_ONES, MID_ONE, 32'd78);
      idle(12);
      check_eq("rst_mid_hash", bus.hash_count, 32'h0);
      check_eq("rst_mid_valid", bus.out_valid, 1'b0);

      // randomised traffic: random gaps (some overruns) and random drain
      for (int n = 0; n < 60; n++) begin
         tx  = rand256();
         mid = rand256();
         if ($urandom_range(0, 1) == 1) mid[255:224] = 32'h0 - tx[255:224];
         bus.out_ready = ($urandom_range(0, 3) == 0);
         fire(tx, mid, $urandom());
         repeat ($urandom_range(0, 14)) begin
            bus.out_ready = ($urandom_range(0, 3) == 0);
            step();
         end
      end
      bus.out_ready = 1'b1;
      idle(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
